// File: rtl/pixel_writer_pkg.sv
// Shared types and helpers for the pixel RAM write side: FSM states and the
// byte-lane enable mask used when a word is committed to port A.
package pixel_writer_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Mask of lanes filled up to and including the given lane.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] lane);
        logic [LANES-1:0] m;
        case (lane)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b0111;
            2'd3:    m = 4'b1111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pixel_stream_writer_byte_packer.sv
// Four-lane little-endian byte packer: holds lanes 0..2 of the word in progress
// and presents the completed word (with the incoming byte inserted) plus its fill mask.
module byte_packer
    import pixel_writer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             accept,
    input  logic             flush,
    input  logic [1:0]       lane,
    input  logic [7:0]       byte_in,
    output logic [31:0]      word,
    output logic [LANES-1:0] mask
);

    logic [23:0] lanes_r;

    // Assemble the word as it would be written this cycle; lanes above the
    // current one are always zero so partial words carry no stale bytes.
    always_comb begin
        word = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < lane) begin
                word[8*i +: 8] = lanes_r[8*i +: 8];
            end else if (2'(i) == lane) begin
                word[8*i +: 8] = byte_in;
            end else begin
                word[8*i +: 8] = 8'h00;
            end
        end
        if (lane == 2'd3) begin
            word[31:24] = byte_in;
        end else begin
            word[31:24] = 8'h00;
        end
        mask = lane_mask(lane);
    end

    // Lane storage: emptied whenever a word is handed off or the fill restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_r <= 24'h00_0000;
        end else if (clear || (accept && flush)) begin
            lanes_r <= 24'h00_0000;
        end else if (accept) begin
            case (lane)
                2'd0:    lanes_r[7:0]   <= byte_in;
                2'd1:    lanes_r[15:8]  <= byte_in;
                2'd2:    lanes_r[23:16] <= byte_in;
                default: lanes_r        <= lanes_r;
            endcase
        end else begin
            lanes_r <= lanes_r;
        end
    end

endmodule

// File: rtl/pixel_stream_writer.sv
// Port-A write side of the dual-port pixel RAM: packs a byte stream into 32-bit
// words and issues one registered write per word, one frame per start.
module pixel_stream_writer
    import pixel_writer_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int FRAME_BYTES = 76800,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] address_a,
    output logic [31:0]       data_a,
    output logic [3:0]        byteena_a,
    output logic              wren_a,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(FRAME_BYTES) + 1;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  byte_cnt_r;
    logic [ADDR_W-1:0] word_addr_r;
    logic              accept_s;
    logic              final_s;
    logic              word_done_s;
    logic              start_s;
    logic              clear_s;
    logic [1:0]        lane_s;
    logic [31:0]       word_s;
    logic [3:0]        mask_s;

    assign s_ready     = (state_r == FILL) && !abort;
    assign busy        = (state_r == FILL);
    assign accept_s    = s_valid && s_ready;
    assign lane_s      = byte_cnt_r[1:0];
    assign final_s     = accept_s && (s_last || (byte_cnt_r == CNT_W'(FRAME_BYTES - 1)));
    assign word_done_s = accept_s && ((lane_s == 2'd3) || final_s);
    assign start_s     = (state_r == IDLE) && start && !abort;
    assign clear_s     = abort || start_s;

    byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .accept  (accept_s),
        .flush   (word_done_s),
        .lane    (lane_s),
        .byte_in (s_data),
        .word    (word_s),
        .mask    (mask_s)
    );

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = FILL;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FILL: begin
                    if (final_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = FILL;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State, byte counter and word address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            byte_cnt_r  <= '0;
            word_addr_r <= ADDR_W'(BASE_ADDR);
        end else begin
            state_r <= state_s;
            if (clear_s) begin
                byte_cnt_r <= '0;
            end else if (accept_s) begin
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end
            // Address wraps modulo 2^ADDR_W by plain overflow.
            if (start_s) begin
                word_addr_r <= ADDR_W'(BASE_ADDR);
            end else if (word_done_s) begin
                word_addr_r <= word_addr_r + ADDR_W'(1);
            end else begin
                word_addr_r <= word_addr_r;
            end
        end
    end

    // Port-A write strobe, data and enables, one cycle after the completing byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wren_a    <= 1'b0;
            data_a    <= 32'h0000_0000;
            byteena_a <= 4'b0000;
            address_a <= ADDR_W'(BASE_ADDR);
            done      <= 1'b0;
        end else begin
            wren_a <= word_done_s;
            done   <= (state_r == DONE) && !abort;
            if (word_done_s) begin
                data_a    <= word_s;
                byteena_a <= mask_s;
                address_a <= word_addr_r;
            end else begin
                data_a    <= 32'h0000_0000;
                byteena_a <= 4'b0000;
                address_a <= address_a;
            end
        end
    end

endmodule
